// File: rtl/nonce_reporter.sv
// Queues golden nonces from the hash core and streams each one to the UART as 4 bytes, LSB first; first tx_start 2 cycles after the push is registered.
// Waits on tx_busy per byte, queues nonces while busy and counts drops when full; NONCE_REPORTER_DEDUP_EN drops repeats of the last accepted nonce.
module nonce_reporter #(
    parameter int DEPTH_LOG2   = 2,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  got_ticket,
    input  logic [31:0]           golden_nonce,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  pending,
    output logic                  nonce_sent,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [7:0]            overflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

    state_t                  state, state_nx;
    logic                    got_ticket_q;
    logic                    push, pop, full, accept, drop;
    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [31:0]             shift;
    logic [1:0]              byte_idx;
    logic [CW-1:0]           cnt;

`ifdef NONCE_REPORTER_DEDUP_EN
    logic [31:0]             last_nonce;
    logic                    last_vld;

    assign push = got_ticket & ~got_ticket_q & ~(last_vld && (golden_nonce == last_nonce));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_nonce <= '0;
            last_vld   <= 1'b0;
        end else if (accept) begin
            last_nonce <= golden_nonce;
            last_vld   <= 1'b1;
        end
    end
`else
    assign push = got_ticket & ~got_ticket_q;
`endif

    // A pop frees the head slot in the same cycle, so a push into a full FIFO still fits.
    assign pop    = (state == LOAD);
    assign full   = (fifo_level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= golden_nonce;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got_ticket_q <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow_cnt <= '0;
        end else begin
            got_ticket_q <= got_ticket;
            if (accept) wr_ptr <= wr_ptr + (DEPTH_LOG2)'(1);
            if (pop)    rd_ptr <= rd_ptr + (DEPTH_LOG2)'(1);
            if (accept && !pop)      fifo_level <= fifo_level + (DEPTH_LOG2 + 1)'(1);
            else if (pop && !accept) fifo_level <= fifo_level - (DEPTH_LOG2 + 1)'(1);
            if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        case (state)
            IDLE:    if (fifo_level != '0) state_nx = LOAD;
            LOAD:    state_nx = SEND;
            SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = WAIT_HI;
                end
            end
            // A UART that never acknowledges must not stall the frame forever.
            WAIT_HI: if (tx_busy || cnt == CW'(BUSY_TIMEOUT)) state_nx = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_nx = NEXT;
            NEXT:    state_nx = (byte_idx == 2'd3) ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            byte_idx   <= '0;
            cnt        <= '0;
            nonce_sent <= 1'b0;
        end else begin
            state      <= state_nx;
            nonce_sent <= (state == NEXT) && (byte_idx == 2'd3);
            case (state)
                LOAD: begin
                    shift    <= mem[rd_ptr];
                    byte_idx <= '0;
                end
                SEND:    cnt <= CW'(1);
                WAIT_HI: if (cnt != CW'(BUSY_TIMEOUT)) cnt <= cnt + CW'(1);
                NEXT: begin
                    if (byte_idx != 2'd3) begin
                        shift    <= {8'h00, shift[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data = shift[7:0];
    assign pending = (fifo_level != '0) || (state != IDLE);

endmodule
